b01_line_tx: RTL and testbench

Transmit-side companion to the b01 serial-line comparator FSM. Accepts pairs of parallel words over a valid/ready handshake and shifts them out bit-serially, one bit per clock and both lanes in lockstep, on `line1`/`line2`. Framing strobes let the downstream receiver/checker align to word boundaries. A one-entry holding register allows back-to-back words without bubbles beyond the configured gap.

---
 rtl/b01_pkg.sv | 22 ++
 rtl/b01_pair_shifter.sv | 50 +++++
 rtl/b01_line_tx.sv | 149 ++++++++++++++
 tb/tb_b01_line_tx.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b01_pkg.sv
// rtl/b01_pkg.sv - shared types and defaults for the b01 serial-line blocks
// Contents:
//   b01_state_e   transmitter FSM state (IDLE / SHIFT / GAP)
//   B01_WIDTH     default bits per word on each lane
//   B01_GAP       default idle cycles between words
//   b01_cnt_bits  counter width needed to index 0..n-1
package b01_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } b01_state_e;

  localparam int B01_WIDTH = 8;
  localparam int B01_GAP   = 1;

  function automatic int b01_cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/b01_pair_shifter.sv
// rtl/b01_pair_shifter.sv - two lockstep shift registers feeding line1/line2
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   load           capture word1/word2 (wins over shift)
//   shift          advance both registers one bit, zero filling
//   word1, word2   parallel data to load
//   bit1, bit2     current output bit of each lane (direct flop outputs)
module b01_pair_shifter
  import b01_pkg::*;
#(
  parameter int WIDTH     = B01_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] word1,
  input  logic [WIDTH-1:0] word2,
  output logic             bit1,
  output logic             bit2
);

  logic [WIDTH-1:0] sr1;
  logic [WIDTH-1:0] sr2;

  // Zero fill means the registers are empty once the final bit has been
  // shifted out, so the lanes idle low without any extra gating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr1 <= '0;
      sr2 <= '0;
    end else if (load) begin
      sr1 <= word1;
      sr2 <= word2;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr1 <= {sr1[WIDTH-2:0], 1'b0};
        sr2 <= {sr2[WIDTH-2:0], 1'b0};
      end else begin
        sr1 <= {1'b0, sr1[WIDTH-1:1]};
        sr2 <= {1'b0, sr2[WIDTH-1:1]};
      end
    end
  end

  assign bit1 = MSB_FIRST ? sr1[WIDTH-1] : sr1[0];
  assign bit2 = MSB_FIRST ? sr2[WIDTH-1] : sr2[0];

endmodule

// File: rtl/b01_line_tx.sv
// rtl/b01_line_tx.sv - b01 two-lane serial transmitter with one-entry holding register
// Ports:
//   clock, reset     clock and asynchronous active-high reset
//   in_valid         word pair offered
//   in_ready         pair can be accepted (holding register empty)
//   word1, word2     parallel words for line1 / line2
//   line1, line2     serial lanes, one bit per clock, low when not framing
//   frame            a data bit is on the lanes this cycle
//   last             final bit of the current word
//   busy             shifting, in the gap, or a word is held
//   word_cnt         completed words, wraps at 256
module b01_line_tx
  import b01_pkg::*;
#(
  parameter int WIDTH     = B01_WIDTH,
  parameter int GAP       = B01_GAP,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] word1,
  input  logic [WIDTH-1:0] word2,
  output logic             line1,
  output logic             line2,
  output logic             frame,
  output logic             last,
  output logic             busy,
  output logic [7:0]       word_cnt
);

  localparam int CW = b01_cnt_bits(WIDTH);
  localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_PENULT = CW'(WIDTH - 2);
  localparam logic [3:0]    GAP_LAST   = 4'((GAP > 0) ? (GAP - 1) : 0);

  b01_state_e       state;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             hold_full;
  logic [WIDTH-1:0] hold1;
  logic [WIDTH-1:0] hold2;

  logic             accept;
  logic             word_end;
  logic             gap_end;
  logic             can_load;
  logic             load;
  logic             load_hold;
  logic             shift;
  logic [WIDTH-1:0] load1;
  logic [WIDTH-1:0] load2;

  assign in_ready  = ~hold_full;
  assign accept    = in_valid & in_ready;
  assign word_end  = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
  assign gap_end   = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  // With no gap the next word may start on the edge that ends the current one.
  assign can_load  = (state == ST_IDLE) || (word_end && (GAP == 0)) || gap_end;
  assign load      = can_load && (hold_full || accept);
  assign load_hold = load && hold_full;
  assign shift     = (state == ST_SHIFT) && !load;
  // A held word is always older than anything on the input, so it goes first.
  assign load1     = hold_full ? hold1 : word1;
  assign load2     = hold_full ? hold2 : word2;
  assign busy      = (state != ST_IDLE) || hold_full;

  b01_pair_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .word1 (load1),
    .word2 (load2),
    .bit1  (line1),
    .bit2  (line2)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      hold_full <= 1'b0;
      hold1     <= '0;
      hold2     <= '0;
      frame     <= 1'b0;
      last      <= 1'b0;
      word_cnt  <= '0;
    end else begin
      // accept and load_hold never coincide: in_ready is low while holding.
      if (accept && !load) begin
        hold1     <= word1;
        hold2     <= word2;
        hold_full <= 1'b1;
      end else if (load_hold) begin
        hold_full <= 1'b0;
      end

      frame <= load || ((state == ST_SHIFT) && !word_end);
      last  <= (state == ST_SHIFT) && (bit_cnt == BIT_PENULT) && !load;

      if (word_end) begin
        word_cnt <= word_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (load) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (word_end) begin
            if (GAP > 0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else if (load) begin
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            if (load) begin
              state   <= ST_SHIFT;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_b01_line_tx.sv
// tb/tb_b01_line_tx.sv - self-checking bench for b01_line_tx (three parameter sets)
module tb_b01_line_tx;
  import b01_pkg::*;

  localparam int W    = 8;
  localparam int NI   = 3;
  localparam int MAXW = 700;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NI-1:0] in_valid = '0;
  logic [NI-1:0] in_ready, line1, line2, frame, last, busy;
  logic [W-1:0]  word1 [NI];
  logic [W-1:0]  word2 [NI];
  logic [7:0]    word_cnt [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Transaction-level model: per word, the accept edge and the load edge.
  int           nw [NI];
  int           ac [NI][MAXW];
  int           ld [NI][MAXW];
  logic [W-1:0] m1 [NI][MAXW];
  logic [W-1:0] m2 [NI][MAXW];

  always #5 clock = ~clock;

  b01_line_tx #(.WIDTH(W), .GAP(1), .MSB_FIRST(1'b0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .word1(word1[0]), .word2(word2[0]), .line1(line1[0]), .line2(line2[0]),
    .frame(frame[0]), .last(last[0]), .busy(busy[0]), .word_cnt(word_cnt[0]));

  b01_line_tx #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b0)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .word1(word1[1]), .word2(word2[1]), .line1(line1[1]), .line2(line2[1]),
    .frame(frame[1]), .last(last[1]), .busy(busy[1]), .word_cnt(word_cnt[1]));

  b01_line_tx #(.WIDTH(W), .GAP(3), .MSB_FIRST(1'b1)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .word1(word1[2]), .word2(word2[2]), .line1(line1[2]), .line2(line2[2]),
    .frame(frame[2]), .last(last[2]), .busy(busy[2]), .word_cnt(word_cnt[2]));

  function automatic int gap_of(int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic bit msb_of(int i);
    return (i == 2);
  endfunction

  function automatic int m_active(int i);
    for (int k = nw[i] - 1; k >= 0; k--)
      if (ld[i][k] <= cyc && cyc < ld[i][k] + W) return k;
    return -1;
  endfunction

  function automatic logic m_bit(int i, int lane);
    int k;
    int b;
    k = m_active(i);
    if (k < 0) return 1'b0;
    b = cyc - ld[i][k];
    if (msb_of(i)) b = W - 1 - b;
    return (lane == 1) ? m1[i][k][b] : m2[i][k][b];
  endfunction

  function automatic logic m_ready(int i);
    int k;
    k = nw[i] - 1;
    if (k < 0) return 1'b1;
    return !(ac[i][k] <= cyc && cyc < ld[i][k]);
  endfunction

  function automatic logic m_busy(int i);
    for (int k = 0; k < nw[i]; k++)
      if (ac[i][k] <= cyc && cyc < ld[i][k] + W + gap_of(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_cnt(int i);
    int n;
    n = 0;
    for (int k = 0; k < nw[i]; k++)
      if (ld[i][k] + W <= cyc) n++;
    return 8'(n % 256);
  endfunction

  function automatic logic [13:0] m_vec(int i);
    int  k;
    logic lst;
    k   = m_active(i);
    lst = (k >= 0) && (cyc == ld[i][k] + W - 1);
    return {m_ready(i), m_bit(i, 1), m_bit(i, 2), (k >= 0), lst, m_busy(i), m_cnt(i)};
  endfunction

  function automatic logic [13:0] dut_vec(int i);
    return {in_ready[i], line1[i], line2[i], frame[i], last[i], busy[i], word_cnt[i]};
  endfunction

  // One clock: note which instances complete a handshake, advance, sample point #1 later.
  task automatic step(output logic [NI-1:0] acc);
    int k;
    for (int i = 0; i < NI; i++) acc[i] = in_valid[i] && m_ready(i);
    @(posedge clock);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (acc[i] && nw[i] < MAXW) begin
        k = nw[i];
        ac[i][k] = cyc;
        if (k == 0 || ld[i][k-1] + W + gap_of(i) <= cyc) ld[i][k] = cyc;
        else ld[i][k] = ld[i][k-1] + W + gap_of(i);
        m1[i][k] = word1[i];
        m2[i][k] = word2[i];
        nw[i] = k + 1;
      end
    end
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NI; i++) nw[i] = 0;
  endtask

  task automatic do_reset();
    logic [NI-1:0] acc;
    in_valid = '0;
    reset = 1'b1;
    clear_model();
    step(acc);
    step(acc);
    reset = 1'b0;
    step(acc);
  endtask

  task automatic test_reset();
    logic [NI-1:0] acc;
    in_valid = '0;
    reset = 1'b1;
    clear_model();
    step(acc);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if ({line1[i], line2[i], frame[i], last[i], busy[i], word_cnt[i]} !== 13'd0)
        $display("FAIL reset_outs inst%0d: got %b/%0d want all 0", i,
                 {line1[i], line2[i], frame[i], last[i], busy[i]}, word_cnt[i]);
      else n_pass++;
    end
    reset = 1'b0;
    step(acc);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (in_ready[i] !== 1'b1) $display("FAIL reset_ready inst%0d: got %b want 1", i, in_ready[i]);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [NI-1:0] acc;
    bit exp1 [8];
    bit exp2 [8];
    exp1 = '{1, 0, 1, 0, 0, 1, 0, 1};
    exp2 = '{0, 0, 1, 1, 1, 1, 0, 0};
    do_reset();
    in_valid[0] = 1'b1;
    word1[0] = 8'hA5;
    word2[0] = 8'h3C;
    step(acc);
    in_valid[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if ({line1[0], line2[0], frame[0], last[0]} !== {exp1[c], exp2[c], 1'b1, (c == 7)})
        $display("FAIL single_bit%0d: got l1/l2/fr/last=%b want %b", c,
                 {line1[0], line2[0], frame[0], last[0]}, {exp1[c], exp2[c], 1'b1, (c == 7)});
      else n_pass++;
      step(acc);
    end
    n_checks++;
    if ({line1[0], line2[0], frame[0], last[0]} !== 4'b0000 || word_cnt[0] !== 8'd1)
      $display("FAIL single_end: got lines/frame/last=%b cnt=%0d want 0000 cnt=1",
               {line1[0], line2[0], frame[0], last[0]}, word_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [NI-1:0] acc;
    logic [27:0]   seen;
    logic [27:0]   want;
    int            sent;
    int            first;
    bit            saw_low;
    do_reset();
    seen = '0;
    sent = 0;
    first = -1;
    saw_low = 0;
    for (int j = 0; j < 28; j++) want[j] = (j < 26) && ((j % 9) < 8);
    in_valid[0] = 1'b1;
    word1[0] = 8'($urandom);
    word2[0] = 8'($urandom);
    for (int c = 0; c < 40; c++) begin
      n_checks++;
      if (in_ready[0] !== m_ready(0))
        $display("FAIL stream_ready cyc%0d: got %b want %b", c, in_ready[0], m_ready(0));
      else n_pass++;
      if (in_ready[0] === 1'b0) saw_low = 1;
      step(acc);
      if (acc[0]) begin
        sent++;
        if (sent == 3) in_valid[0] = 1'b0;
        word1[0] = 8'($urandom);
        word2[0] = 8'($urandom);
      end
      if (frame[0] && first < 0) first = c;
      if (first >= 0 && c - first < 28) seen[c - first] = frame[0];
    end
    n_checks++;
    if (seen !== want) $display("FAIL stream_frame: got %b want %b", seen, want);
    else n_pass++;
    n_checks++;
    if (saw_low !== 1'b1) $display("FAIL stream_ready_low: got %b want 1", saw_low);
    else n_pass++;
    n_checks++;
    if (word_cnt[0] !== 8'd3) $display("FAIL stream_cnt: got %0d want 3", word_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_gap0();
    logic [NI-1:0] acc;
    logic [31:0]   fv;
    logic [31:0]   lv;
    int            sent;
    int            first;
    do_reset();
    fv = '0;
    lv = '0;
    sent = 0;
    first = -1;
    in_valid[1] = 1'b1;
    word1[1] = 8'($urandom);
    word2[1] = 8'($urandom);
    for (int c = 0; c < 30; c++) begin
      step(acc);
      if (acc[1]) begin
        sent++;
        if (sent == 2) in_valid[1] = 1'b0;
        word1[1] = 8'($urandom);
        word2[1] = 8'($urandom);
      end
      if (frame[1] && first < 0) first = c;
      if (first >= 0 && c - first < 32) begin
        fv[c - first] = frame[1];
        lv[c - first] = last[1];
      end
    end
    n_checks++;
    if (fv !== 32'h0000_FFFF) $display("FAIL gap0_frame: got %h want 0000ffff", fv);
    else n_pass++;
    n_checks++;
    if (lv !== 32'h0000_8080) $display("FAIL gap0_last: got %h want 00008080", lv);
    else n_pass++;
  endtask

  task automatic test_msb();
    logic [NI-1:0] acc;
    logic [7:0]    w2;
    do_reset();
    w2 = 8'($urandom);
    in_valid[2] = 1'b1;
    word1[2] = 8'h01;
    word2[2] = w2;
    step(acc);
    in_valid[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if ({line1[2], line2[2], last[2]} !== {(c == 7), w2[7 - c], (c == 7)})
        $display("FAIL msb_bit%0d: got l1/l2/last=%b want %b", c,
                 {line1[2], line2[2], last[2]}, {(c == 7), w2[7 - c], (c == 7)});
      else n_pass++;
      step(acc);
    end
  endtask

  task automatic test_reset_mid();
    logic [NI-1:0] acc;
    do_reset();
    in_valid[0] = 1'b1;
    word1[0] = 8'hFF;
    word2[0] = 8'hF0;
    step(acc);
    word1[0] = 8'($urandom);
    word2[0] = 8'($urandom);
    step(acc);
    in_valid[0] = 1'b0;
    step(acc);
    step(acc);
    step(acc);
    n_checks++;
    if ({line1[0], line2[0], frame[0], in_ready[0], busy[0]} !== 5'b11101)
      $display("FAIL midrst_before: got l1/l2/fr/rdy/busy=%b want 11101",
               {line1[0], line2[0], frame[0], in_ready[0], busy[0]});
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({line1[0], line2[0], frame[0], last[0], busy[0]} !== 5'b00000 || word_cnt[0] !== 8'd0)
      $display("FAIL midrst_async: got l1/l2/fr/last/busy=%b cnt=%0d want 00000 cnt=0",
               {line1[0], line2[0], frame[0], last[0], busy[0]}, word_cnt[0]);
    else n_pass++;
    clear_model();
    step(acc);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(acc);
      n_checks++;
      if ({frame[0], busy[0], in_ready[0]} !== 3'b001 || word_cnt[0] !== 8'd0)
        $display("FAIL midrst_idle cyc%0d: got fr/busy/rdy=%b cnt=%0d want 001 cnt=0", c,
                 {frame[0], busy[0], in_ready[0]}, word_cnt[0]);
      else n_pass++;
    end
    in_valid[0] = 1'b1;
    word1[0] = 8'($urandom);
    word2[0] = 8'($urandom);
    step(acc);
    in_valid[0] = 1'b0;
    for (int c = 0; c < 11; c++) begin
      n_checks++;
      if (dut_vec(0) !== m_vec(0))
        $display("FAIL midrst_next cyc%0d: got %h want %h", c, dut_vec(0), m_vec(0));
      else n_pass++;
      step(acc);
    end
    n_checks++;
    if (word_cnt[0] !== 8'd1) $display("FAIL midrst_cnt: got %0d want 1", word_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [NI-1:0] acc;
    int            sent;
    int            lasts;
    bit            done;
    do_reset();
    sent = 0;
    lasts = 0;
    done = 0;
    in_valid[1] = 1'b1;
    for (int c = 0; c < 256 * W + 64 && !done; c++) begin
      word1[1] = 8'($urandom);
      word2[1] = 8'($urandom);
      step(acc);
      if (acc[1]) begin
        sent++;
        if (sent == 256) in_valid[1] = 1'b0;
      end
      if (last[1]) begin
        lasts++;
        if (lasts == 256) begin
          n_checks++;
          if (word_cnt[1] !== 8'd255) $display("FAIL wrap_before: got %0d want 255", word_cnt[1]);
          else n_pass++;
          step(acc);
          n_checks++;
          if (word_cnt[1] !== 8'd0) $display("FAIL wrap_after: got %0d want 0", word_cnt[1]);
          else n_pass++;
          done = 1;
        end
      end
    end
    n_checks++;
    if (!done) $display("FAIL wrap_timeout: got %0d last pulses want 256", lasts);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NI-1:0] acc;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      if (c == 450) begin
        in_valid = '0;
        reset = 1'b1;
        clear_model();
        #1;
      end
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (dut_vec(i) !== m_vec(i))
          $display("FAIL rand inst%0d cyc%0d: got %h want %h", i, c, dut_vec(i), m_vec(i));
        else n_pass++;
      end
      step(acc);
      reset = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (acc[i] || !in_valid[i]) begin
          in_valid[i] = ($urandom_range(0, 3) != 0);
          word1[i] = 8'($urandom);
          word2[i] = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      word1[i] = '0;
      word2[i] = '0;
    end
    clear_model();
    test_reset();
    test_single();
    test_stream();
    test_gap0();
    test_msb();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
